// File: rtl/adc_serial_if.sv
// Serial ADC front end: Conv strobe, 16 SCK periods of MSB-first capture, one-cycle Done pulse.
// Latency: Done at T+ConvCycles+32*DivHalf+1 after a sampled request (x4 sequences when oversampling).
// Backpressure: none; a held request yields one conversion, a new one needs AdcStart_i to drop first.
//
// Ports: Clk_i/Reset_i (sync, active high), AdcStart_i level request, AdcDone_o pulse,
//        AdcValue_o 16-bit result (held), AdcBusy_o, AdcCnv_o, AdcSck_o, AdcSdo_i.
// Build option: define ADC_SERIAL_IF_OVERSAMPLE_EN to average four back-to-back samples.
module adc_serial_if #(
    parameter int DivHalf    = 2,
    parameter int ConvCycles = 40
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        AdcStart_i,
    output logic        AdcDone_o,
    output logic [15:0] AdcValue_o,
    output logic        AdcBusy_o,
    output logic        AdcCnv_o,
    output logic        AdcSck_o,
    input  logic        AdcSdo_i
);

    typedef enum logic [2:0] {
        Idle,
        Conv,
        Shift,
        Done,
        WaitRelease
    } state_t;

    localparam logic [9:0] ConvLast = 10'(ConvCycles - 1);
    localparam logic [7:0] DivLast  = 8'(DivHalf - 1);

    state_t      state;
    logic [9:0]  convCnt;
    logic [7:0]  divCnt;
    logic [4:0]  halfCnt;   // SCK half-period index 0..31; even = low half
    logic [15:0] shiftReg;

`ifdef ADC_SERIAL_IF_OVERSAMPLE_EN
    logic [1:0]  seqCnt;
    logic [17:0] accum;
    logic [17:0] accSum;

    // shiftReg is complete at the final Shift edge: the last capture happened
    // at the start of the last high half.
    always_comb begin
        accSum = accum + {2'b00, shiftReg};
    end
`endif

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state      <= Idle;
            convCnt    <= '0;
            divCnt     <= '0;
            halfCnt    <= '0;
            shiftReg   <= '0;
            AdcDone_o  <= 1'b0;
            AdcValue_o <= '0;
            AdcBusy_o  <= 1'b0;
            AdcCnv_o   <= 1'b0;
            AdcSck_o   <= 1'b0;
`ifdef ADC_SERIAL_IF_OVERSAMPLE_EN
            seqCnt     <= '0;
            accum      <= '0;
`endif
        end else begin
            case (state)
                Idle: begin
                    if (AdcStart_i) begin
                        state     <= Conv;
                        AdcCnv_o  <= 1'b1;
                        AdcBusy_o <= 1'b1;
                        convCnt   <= '0;
`ifdef ADC_SERIAL_IF_OVERSAMPLE_EN
                        seqCnt    <= '0;
                        accum     <= '0;
`endif
                    end
                end

                Conv: begin
                    if (convCnt == ConvLast) begin
                        state    <= Shift;
                        AdcCnv_o <= 1'b0;
                        convCnt  <= '0;
                        divCnt   <= '0;
                        halfCnt  <= '0;
                    end else begin
                        convCnt <= convCnt + 10'd1;
                    end
                end

                Shift: begin
                    if (divCnt == DivLast) begin
                        divCnt   <= '0;
                        halfCnt  <= halfCnt + 5'd1;
                        AdcSck_o <= ~AdcSck_o;
                        // This edge raises SCK: capture the bit the ADC is presenting.
                        if (!halfCnt[0]) begin
                            shiftReg <= {shiftReg[14:0], AdcSdo_i};
                        end
                        if (halfCnt == 5'd31) begin
`ifdef ADC_SERIAL_IF_OVERSAMPLE_EN
                            if (seqCnt == 2'd3) begin
                                state      <= Done;
                                AdcDone_o  <= 1'b1;
                                AdcValue_o <= accSum[17:2];
                            end else begin
                                seqCnt   <= seqCnt + 2'd1;
                                accum    <= accSum;
                                state    <= Conv;
                                AdcCnv_o <= 1'b1;
                                convCnt  <= '0;
                            end
`else
                            state      <= Done;
                            AdcDone_o  <= 1'b1;
                            AdcValue_o <= shiftReg;
`endif
                        end
                    end else begin
                        divCnt <= divCnt + 8'd1;
                    end
                end

                Done: begin
                    AdcDone_o <= 1'b0;
                    AdcBusy_o <= 1'b0;
                    state     <= AdcStart_i ? WaitRelease : Idle;
                end

                WaitRelease: begin
                    if (!AdcStart_i) begin
                        state <= Idle;
                    end
                end

                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_if.sv
// Directed bench for adc_serial_if: default instance plus a DivHalf=1/ConvCycles=1 instance.
// Each instance has a behavioural ADC that loads a queued word on AdcCnv_o rising and
// presents the next bit after every AdcSck_o falling edge.
module tb_adc_serial_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done, busy, cnv, sck, sdo;
    logic [15:0] value;

    logic        start2 = 1'b0;
    logic        done2, busy2, cnv2, sck2, sdo2;
    logic [15:0] value2;

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    adc_serial_if dut (
        .Clk_i(clk), .Reset_i(rst), .AdcStart_i(start), .AdcDone_o(done),
        .AdcValue_o(value), .AdcBusy_o(busy), .AdcCnv_o(cnv), .AdcSck_o(sck), .AdcSdo_i(sdo)
    );

    adc_serial_if #(.DivHalf(1), .ConvCycles(1)) dutFast (
        .Clk_i(clk), .Reset_i(rst), .AdcStart_i(start2), .AdcDone_o(done2),
        .AdcValue_o(value2), .AdcBusy_o(busy2), .AdcCnv_o(cnv2), .AdcSck_o(sck2), .AdcSdo_i(sdo2)
    );

    // ADC models
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] sreg1 = '0;
    logic [15:0] sreg2 = '0;
    assign sdo  = sreg1[15];
    assign sdo2 = sreg2[15];

    always @(posedge cnv)  sreg1 = (q1.size() > 0) ? q1.pop_front() : 16'h0000;
    always @(negedge sck)  sreg1 = {sreg1[14:0], 1'b0};
    always @(posedge cnv2) sreg2 = (q2.size() > 0) ? q2.pop_front() : 16'h0000;
    always @(negedge sck2) sreg2 = {sreg2[14:0], 1'b0};

    // Observation results for the default instance
    int cnvFirst, cnvLast, sckRises, doneCyc, doneCnt, busyFallCyc, valChanged;

    // Called at the negedge of cycle T with start already high; releases start after holdCycles.
    task automatic watch(input int budget, input int holdCycles, input bit stopEarly);
        logic prevSck;
        logic [15:0] prevVal;
        cnvFirst = -1; cnvLast = -1; sckRises = 0; doneCyc = -1; doneCnt = 0;
        busyFallCyc = -1; valChanged = 0;
        prevSck = sck;
        prevVal = value;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cnv) begin
                if (cnvFirst < 0) cnvFirst = cyc;
                cnvLast = cyc;
            end
            if (!prevSck && sck) sckRises++;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end else if (value !== prevVal) begin
                valChanged++;
            end
            if (doneCnt > 0 && !busy && busyFallCyc < 0) busyFallCyc = cyc;
            prevSck = sck;
            prevVal = value;
            if (i + 1 == holdCycles) start = 1'b0;
            if (stopEarly && busyFallCyc >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;   // reset must win over a pending request
        repeat (3) @(negedge clk);
        nVec++;
        if ({done, busy, cnv, sck, value} !== 20'h0) begin
            nErr++;
            $display("FAIL reset_outputs: got done=%b busy=%b cnv=%b sck=%b value=%h, want all 0",
                     done, busy, cnv, sck, value);
        end
        nVec++;
        if ({done2, busy2, cnv2, sck2, value2} !== 20'h0) begin
            nErr++;
            $display("FAIL reset_outputs_fast: got done=%b busy=%b cnv=%b sck=%b value=%h, want all 0",
                     done2, busy2, cnv2, sck2, value2);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int t;
        q1.push_back(16'hA5C3);
        t = cyc;
        start = 1'b1;
        watch(200, 1, 1'b1);
        nVec++;
        if (cnvFirst != t + 1 || cnvLast != t + 40) begin
            nErr++;
            $display("FAIL single_cnv: got %0d..%0d, want %0d..%0d", cnvFirst - t, cnvLast - t, 1, 40);
        end
        nVec++;
        if (sckRises != 16) begin
            nErr++;
            $display("FAIL single_sck: got %0d pulses, want 16", sckRises);
        end
        nVec++;
        if (doneCyc != t + 105 || doneCnt != 1) begin
            nErr++;
            $display("FAIL single_done: got T+%0d count %0d, want T+105 count 1", doneCyc - t, doneCnt);
        end
        nVec++;
        if (value !== 16'hA5C3) begin
            nErr++;
            $display("FAIL single_value: got %h, want a5c3", value);
        end
        nVec++;
        if (busyFallCyc != t + 106) begin
            nErr++;
            $display("FAIL single_busy: low at T+%0d, want T+106", busyFallCyc - t);
        end
    endtask

    task automatic test_hold();
        int t;
        q1.push_back(16'h1357);
        q1.push_back(16'h2468);
        start = 1'b1;
        watch(300, 300, 1'b0);
        nVec++;
        if (doneCnt != 1 || value !== 16'h1357) begin
            nErr++;
            $display("FAIL hold_once: got %0d done pulses value %h, want 1 and 1357", doneCnt, value);
        end
        // start dropped at end of the watch; keep it low one cycle, then reassert
        @(negedge clk);
        t = cyc;
        start = 1'b1;
        watch(200, 1, 1'b1);
        nVec++;
        if (doneCyc != t + 105 || value !== 16'h2468) begin
            nErr++;
            $display("FAIL hold_rearm: got done T+%0d value %h, want T+105 value 2468", doneCyc - t, value);
        end
    endtask

    task automatic test_reset_mid_shift();
        int t;
        int sawDone;
        q1.push_back(16'hDEAD);
        t = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nVec++;
        if ({done, busy, cnv, sck, value} !== 20'h0) begin
            nErr++;
            $display("FAIL reset_mid_outputs: got done=%b busy=%b cnv=%b sck=%b value=%h, want all 0",
                     done, busy, cnv, sck, value);
        end
        sawDone = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) sawDone++;
        end
        nVec++;
        if (sawDone != 0) begin
            nErr++;
            $display("FAIL reset_mid_nodone: got %0d done pulses, want 0", sawDone);
        end
        q1.push_back(16'h1234);
        t = cyc;
        start = 1'b1;
        watch(200, 1, 1'b1);
        nVec++;
        if (doneCyc != t + 105 || value !== 16'h1234) begin
            nErr++;
            $display("FAIL reset_mid_recover: got done T+%0d value %h, want T+105 value 1234", doneCyc - t, value);
        end
    endtask

    task automatic test_back_to_back();
        int changes;
        q1.push_back(16'hFFFF);
        q1.push_back(16'h0000);
        start = 1'b1;
        watch(200, 1, 1'b1);
        changes = valChanged;
        nVec++;
        if (value !== 16'hFFFF) begin
            nErr++;
            $display("FAIL b2b_first: got %h, want ffff", value);
        end
        start = 1'b1;   // request in the first Idle cycle after Done
        watch(200, 1, 1'b1);
        changes += valChanged;
        nVec++;
        if (value !== 16'h0000 || doneCnt != 1) begin
            nErr++;
            $display("FAIL b2b_second: got %h count %0d, want 0000 count 1", value, doneCnt);
        end
        nVec++;
        if (changes != 0) begin
            nErr++;
            $display("FAIL b2b_stable: value changed %0d times outside Done, want 0", changes);
        end
    endtask

    task automatic test_fast();
        int t, dc, dn;
        q2.push_back(16'h8001);
        t = cyc;
        start2 = 1'b1;
        dc = -1;
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) begin
                dn++;
                if (dc < 0) dc = cyc;
            end
        end
        nVec++;
        if (dc != t + 34 || dn != 1) begin
            nErr++;
            $display("FAIL fast_done: got T+%0d count %0d, want T+34 count 1", dc - t, dn);
        end
        nVec++;
        if (value2 !== 16'h8001) begin
            nErr++;
            $display("FAIL fast_value: got %h, want 8001", value2);
        end
    endtask

`ifdef ADC_SERIAL_IF_OVERSAMPLE_EN
    task automatic test_oversample();
        int t;
        q1.push_back(16'h0001); q1.push_back(16'h0002);
        q1.push_back(16'h0003); q1.push_back(16'h0004);
        t = cyc;
        start = 1'b1;
        watch(500, 1, 1'b1);
        nVec++;
        if (doneCyc != t + 417 || doneCnt != 1) begin
            nErr++;
            $display("FAIL os_done: got T+%0d count %0d, want T+417 count 1", doneCyc - t, doneCnt);
        end
        nVec++;
        if (value !== 16'h0002 || sckRises != 64) begin
            nErr++;
            $display("FAIL os_avg: got %h sck %0d, want 0002 sck 64", value, sckRises);
        end
        repeat (4) q1.push_back(16'hFFFF);
        start = 1'b1;
        watch(500, 1, 1'b1);
        nVec++;
        if (value !== 16'hFFFF) begin
            nErr++;
            $display("FAIL os_full: got %h, want ffff", value);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_SERIAL_IF_OVERSAMPLE_EN
        test_oversample();
`else
        test_single();
        test_hold();
        test_reset_mid_shift();
        test_back_to_back();
`endif
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
